spi_slave_responder: RTL and testbench
======================================

Name: spi_slave_responder

Overview:
SPI target (responder) for the SoC's SPI master port (MISO in; MOSI/SCLK/SS_n out), used for loopback verification and for on-chip peripherals hung off that bus. Operates in SPI mode 0 (CPOL=0, CPHA=0), MSB first. Oversamples SCLK/SS_n/MOSI in the clk_clk domain. Presents received bytes on a pulse interface and takes transmit bytes through a one-entry ready/valid holding register.

Parameters:
DATA_W, 8, bits per SPI word
SYNC_STAGES, 2, synchronizer flops on SCLK/SS_n/MOSI (min 2)
IDLE_BYTE, 8'hFF, word shifted out on MISO when no tx data is held

Ports:
clk_clk  in  1  system clock; all logic on rising edge
reset_reset_n  in  1  synchronous reset, active-low
spi_SCLK  in  1  SPI clock from master (async)
spi_MOSI  in  1  master-out data (async)
spi_SS_n  in  1  target select, active-low (async)
spi_MISO  out  1  target-out data
spi_MISO_oe  out  1  MISO output enable, high while selected
rx_data  out  DATA_W  last complete received word
rx_valid  out  1  one-cycle pulse, rx_data updated
tx_data  in  DATA_W  next word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty
tx_underrun  out  1  one-cycle pulse, IDLE_BYTE substituted
frame_end  out  1  one-cycle pulse on SS_n deassert
busy  out  1  high while selected

Behaviour:
- Clock and reset: one clock (clk_clk); reset_reset_n is synchronous, active-low.
- Reset values: spi_MISO=1, spi_MISO_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, frame_end=0, busy=0. Synchronizers are cleared to SCLK=0, SS_n=1, MOSI=0. Holding register is empty.
- Input path: SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
  - Edge detect compares the synced value with a one-cycle-delayed copy.
  - Edge cycle E is the cycle in which the synced value differs from the delayed copy.
  - Legal SCLK frequency is at most clk_clk/8.
- FSM has two states, IDLE and ACTIVE.
  - IDLE -> ACTIVE on the synced SS_n falling edge. In that cycle:
    - bit_cnt=0;
    - tx shift register is loaded (load rule below);
    - busy=1 and spi_MISO_oe=1 from E+1.
  - ACTIVE -> IDLE on the synced SS_n rising edge:
    - partial rx word discarded, no rx_valid;
    - frame_end pulses at E+1;
    - busy=0 and spi_MISO_oe=0 at E+1; spi_MISO returns to 1;
    - a tx word already moved into the shift register is consumed, not restored.
- SCLK rising edge (ACTIVE only):
  - shift_rx = {shift_rx[DATA_W-2:0], MOSI_sync}; bit_cnt increments.
  - At bit_cnt==DATA_W-1: bit_cnt wraps to 0, rx_data takes the completed word, rx_valid pulses at E+1, and byte_done is set.
- SCLK falling edge (ACTIVE only):
  - If byte_done is set: load the next tx word and clear byte_done.
  - Otherwise: shift shift_tx left by 1.
  - spi_MISO always equals shift_tx[DATA_W-1].
- Tx load rule, in priority order:
  1. Holding register full: shift_tx = holding; holding becomes empty; tx_ready=1 at E+1.
  2. Holding register empty and tx_valid=1 in the same cycle: bypass tx_data straight into shift_tx. The handshake completes; no underrun.
  3. Otherwise: shift_tx = IDLE_BYTE and tx_underrun pulses at E+1.
- Holding register: accepts a word when tx_valid && tx_ready, outside a load cycle.
- rx path has no backpressure; the consumer must take rx_data on rx_valid.
- SCLK edges while in IDLE are ignored.
- SS_n and SCLK edges detected in the same cycle: the SS_n edge takes priority and the SCLK edge is dropped.
- Any cycle with reset_reset_n=0 forces reset values regardless of state, including mid-word.

Decomposition:
- Package spi_slave_pkg holds:
  - the state enum (IDLE, ACTIVE);
  - DATA_W and IDLE_BYTE defaults;
  - a SPI_MODE0 constant.
- Sub-module spi_input_sync holds the SYNC_STAGES synchronizer plus rise/fall detect, instantiated once per input (SCLK, SS_n, MOSI).

Test Plan:
- Preload tx_data=8'hA5 while idle, then master sends 8'h3C with SCLK=clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_valid one pulse with rx_data=8'h3C; tx_ready re-asserts after the SS_n fall.
- No tx data loaded; master sends 2 words -> MISO=8'hFF twice; tx_underrun pulses twice; rx_valid pulses twice.
- tx_valid held with 8'h11 then 8'h22; 2-word frame -> MISO 8'h11, 8'h22; no underrun.
- SS_n raised after 5 SCLKs -> no rx_valid; frame_end one pulse; MISO_oe=0; next frame's first rx_data is correct.
- Reset asserted mid-word (bit 4), then released and a new frame sent -> all outputs at reset values; new word received correctly.
- SCLK toggled with SS_n=1 -> no rx_valid; MISO_oe stays 0.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_slave_pkg;

    localparam int         DATA_W_DEF    = 8;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Where the next outgoing word comes from when the tx shifter is reloaded.
    typedef enum logic [1:0] {
        LOAD_HOLD   = 2'd0,
        LOAD_BYPASS = 2'd1,
        LOAD_IDLE   = 2'd2
    } load_src_t;

endpackage

// File: rtl/spi_slave_responder_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin plus rise/fall detect.
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   dly_q;

    // Shift the pin through the synchronizer; keep a one-cycle-delayed copy for edge detect.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q   <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
            dly_q   <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = chain_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_o = ~chain_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target: oversampled SCLK/SS_n/MOSI, rx word pulse interface,
// one-entry tx holding register with bypass and idle-byte substitution.
//
// state  | meaning
// IDLE   | not selected, MISO driven 1 with output enable low
// ACTIVE | selected, shifting words on SCLK edges
module spi_slave_responder
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              spi_SCLK,
    input  logic              spi_MOSI,
    input  logic              spi_SS_n,
    output logic              spi_MISO,
    output logic              spi_MISO_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_end,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
    localparam bit SAMPLE_ON_RISE = (SPI_MODE0[1] == SPI_MODE0[0]);

    logic sclk_rise, sclk_fall, sclk_sync_unused;
    logic ss_sync, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .async_i (spi_SCLK),
        .sync_o  (sclk_sync_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .async_i (spi_SS_n),
        .sync_o  (ss_sync),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .async_i (spi_MOSI),
        .sync_o  (mosi_sync),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shift_rx_q;
    logic [DATA_W-1:0] shift_tx_q;
    logic              byte_done_q;
    logic [DATA_W-1:0] hold_q;
    logic              tx_ready_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              tx_underrun_q;
    logic              frame_end_q;
    logic              busy_q;
    logic              miso_oe_q;

    logic              start_ev, stop_ev, sclk_ok, sample_ev, shift_ev, load_ev, hold_accept;
    logic              last_bit;
    load_src_t         load_src_d;
    logic [DATA_W-1:0] load_word_d;

    // SS_n edges win over a coincident SCLK edge: synced SS_n high masks SCLK activity.
    assign start_ev    = (state_q == IDLE) && ss_fall;
    assign stop_ev     = (state_q == ACTIVE) && ss_rise;
    assign sclk_ok     = (state_q == ACTIVE) && !ss_sync;
    assign sample_ev   = sclk_ok && (SAMPLE_ON_RISE ? sclk_rise : sclk_fall);
    assign shift_ev    = sclk_ok && (SAMPLE_ON_RISE ? sclk_fall : sclk_rise);
    assign load_ev     = start_ev || (shift_ev && byte_done_q);
    assign hold_accept = tx_valid && tx_ready_q && !load_ev;
    assign last_bit    = (bit_cnt_q == CNT_W'(DATA_W - 1));

    // Pick the next outgoing word: held word, then a same-cycle bypass, else the idle byte.
    always_comb begin
        load_src_d  = LOAD_IDLE;
        load_word_d = IDLE_BYTE;
        if (!tx_ready_q) begin
            load_src_d  = LOAD_HOLD;
            load_word_d = hold_q;
        end else if (tx_valid) begin
            load_src_d  = LOAD_BYPASS;
            load_word_d = tx_data;
        end
    end

    // Frame FSM with shift registers, holding register and registered pulse outputs.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_rx_q    <= '0;
            shift_tx_q    <= '1;
            byte_done_q   <= 1'b0;
            hold_q        <= '0;
            tx_ready_q    <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_end_q   <= 1'b0;

            if (hold_accept) begin
                hold_q     <= tx_data;
                tx_ready_q <= 1'b0;
            end

            if (load_ev) begin
                shift_tx_q  <= load_word_d;
                byte_done_q <= 1'b0;
                if (load_src_d == LOAD_HOLD) begin
                    tx_ready_q <= 1'b1;
                end
                if (load_src_d == LOAD_IDLE) begin
                    tx_underrun_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_ev) begin
                        state_q   <= ACTIVE;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        miso_oe_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (stop_ev) begin
                        state_q     <= IDLE;
                        bit_cnt_q   <= '0;
                        byte_done_q <= 1'b0;
                        shift_tx_q  <= '1;
                        busy_q      <= 1'b0;
                        miso_oe_q   <= 1'b0;
                        frame_end_q <= 1'b1;
                    end else if (sample_ev) begin
                        shift_rx_q <= {shift_rx_q[DATA_W-2:0], mosi_sync};
                        if (last_bit) begin
                            bit_cnt_q   <= '0;
                            rx_data_q   <= {shift_rx_q[DATA_W-2:0], mosi_sync};
                            rx_valid_q  <= 1'b1;
                            byte_done_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (shift_ev && !byte_done_q) begin
                        shift_tx_q <= {shift_tx_q[DATA_W-2:0], 1'b0};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_MISO    = shift_tx_q[DATA_W-1];
    assign spi_MISO_oe = miso_oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: bit-level SPI master, tx producer and a word-level reference model.
module tb_spi_slave_responder;

    localparam logic [7:0] IB = 8'hFF;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       spi_SCLK = 1'b0;
    logic       spi_MOSI = 1'b0;
    logic       spi_SS_n = 1'b1;
    logic       spi_MISO, spi_MISO_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_underrun, frame_end, busy;

    spi_slave_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .spi_SCLK      (spi_SCLK),
        .spi_MOSI      (spi_MOSI),
        .spi_SS_n      (spi_SS_n),
        .spi_MISO      (spi_MISO),
        .spi_MISO_oe   (spi_MISO_oe),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_underrun   (tx_underrun),
        .frame_end     (frame_end),
        .busy          (busy)
    );

    always #5 clk_clk = ~clk_clk;

    int errors = 0;
    int checks = 0;

    // Observed pulses, counted on the falling clock edge.
    logic [7:0] rx_log[$];
    int ur_cnt = 0;
    int fe_cnt = 0;
    always @(negedge clk_clk) begin
        if (rx_valid) rx_log.push_back(rx_data);
        if (tx_underrun) ur_cnt++;
        if (frame_end) fe_cnt++;
    end

    // Producer: presents queued words with valid held until the handshake completes.
    logic [7:0] prod_q[$];
    logic [7:0] model_q[$];
    initial begin
        forever begin
            @(posedge clk_clk);
            if (reset_reset_n && tx_valid && tx_ready) void'(prod_q.pop_front());
            #1;
            if (prod_q.size() > 0) begin
                tx_valid = 1'b1;
                tx_data  = prod_q[0];
            end else begin
                tx_valid = 1'b0;
            end
        end
    end

    task automatic offer(input logic [7:0] w);
        prod_q.push_back(w);
        model_q.push_back(w);
    endtask

    // Master stimulus and observations.
    logic [7:0] m_mosi[4];
    logic [7:0] m_miso[4];
    logic       m_ready_first;
    int         m_oe_bad;

    // Sends nwords full words; tail_bits>0 appends a partial word. With no tail the
    // final SCLK fall and the SS_n rise happen together.
    task automatic master_frame(input int nwords, input int tail_bits);
        int nw;
        int nb;
        nw = nwords + ((tail_bits > 0) ? 1 : 0);
        m_oe_bad = 0;
        spi_SS_n = 1'b0;
        for (int w = 0; w < nw; w++) begin
            nb = (w < nwords) ? 8 : tail_bits;
            for (int b = 0; b < nb; b++) begin
                spi_MOSI = m_mosi[w][7-b];
                repeat (4) @(negedge clk_clk);
                if (w < nwords) m_miso[w][7-b] = spi_MISO;
                if (!spi_MISO_oe || !busy) m_oe_bad++;
                if (w == 0 && b == 0) m_ready_first = tx_ready;
                spi_SCLK = 1'b1;
                repeat (4) @(negedge clk_clk);
                spi_SCLK = 1'b0;
                if (tail_bits == 0 && w == nwords - 1 && b == 7) spi_SS_n = 1'b1;
            end
        end
        if (tail_bits > 0) begin
            repeat (4) @(negedge clk_clk);
            spi_SS_n = 1'b1;
        end
        repeat (8) @(negedge clk_clk);
    endtask

    // Word-level model: every reload takes the oldest offered word or substitutes IB.
    logic [7:0] exp_miso[4];
    int         exp_ur;
    task automatic model_frame(input int nwords, input int tail_bits);
        int loads;
        loads  = nwords + ((tail_bits > 0) ? 1 : 0);
        exp_ur = 0;
        for (int i = 0; i < loads; i++) begin
            if (model_q.size() > 0) begin
                if (i < 4) exp_miso[i] = model_q.pop_front();
                else void'(model_q.pop_front());
            end else begin
                if (i < 4) exp_miso[i] = IB;
                exp_ur++;
            end
        end
    endtask

    task automatic clear_obs();
        rx_log.delete();
        ur_cnt = 0;
        fe_cnt = 0;
    endtask

    task automatic wait_ready_low(input string name);
        int n;
        n = 0;
        while (tx_ready !== 1'b0 && n < 20) begin
            @(negedge clk_clk);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold_fill: tx_ready=%b expected 0 within 20 cycles", name, tx_ready);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({spi_MISO, spi_MISO_oe, busy, rx_valid, tx_underrun, frame_end} !== 6'b100000) begin
            errors++;
            $display("FAIL %s_idle: miso/oe/busy/rxv/ur/fe=%b expected 100000",
                     name, {spi_MISO, spi_MISO_oe, busy, rx_valid, tx_underrun, frame_end});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_clk);
        check_idle_outputs("reset");
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h expected 00", rx_data);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_ready: got %b expected 1", tx_ready);
        end
        reset_reset_n = 1'b1;
        repeat (4) @(negedge clk_clk);
        clear_obs();
    endtask

    task automatic test_preload();
        clear_obs();
        offer(8'hA5);
        wait_ready_low("preload");
        m_mosi[0] = 8'h3C;
        model_frame(1, 0);
        master_frame(1, 0);
        checks++;
        if (m_miso[0] !== exp_miso[0]) begin
            errors++;
            $display("FAIL preload_miso: got %h expected %h", m_miso[0], exp_miso[0]);
        end
        checks++;
        if (rx_log.size() != 1 || rx_log[0] !== 8'h3C) begin
            errors++;
            $display("FAIL preload_rx: count %0d first %h expected 1 x 3c", rx_log.size(),
                     (rx_log.size() > 0) ? rx_log[0] : 8'hxx);
        end
        checks++;
        if (m_ready_first !== 1'b1) begin
            errors++;
            $display("FAIL preload_ready_after_ss: got %b expected 1", m_ready_first);
        end
        checks++;
        if (ur_cnt != exp_ur || fe_cnt != 1 || m_oe_bad != 0) begin
            errors++;
            $display("FAIL preload_pulses: ur=%0d fe=%0d oe_bad=%0d expected %0d 1 0",
                     ur_cnt, fe_cnt, m_oe_bad, exp_ur);
        end
        check_idle_outputs("preload_end");
    endtask

    task automatic test_underrun();
        clear_obs();
        m_mosi[0] = 8'($urandom);
        m_mosi[1] = 8'($urandom);
        model_frame(2, 0);
        master_frame(2, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_miso[i] !== exp_miso[i]) begin
                errors++;
                $display("FAIL underrun_miso%0d: got %h expected %h", i, m_miso[i], exp_miso[i]);
            end
        end
        checks++;
        if (ur_cnt != exp_ur) begin
            errors++;
            $display("FAIL underrun_count: got %0d expected %0d", ur_cnt, exp_ur);
        end
        checks++;
        if (rx_log.size() != 2 || rx_log[0] !== m_mosi[0] || rx_log[1] !== m_mosi[1]) begin
            errors++;
            $display("FAIL underrun_rx: count %0d expected 2 words %h %h", rx_log.size(), m_mosi[0], m_mosi[1]);
        end
    endtask

    task automatic test_held_tx();
        clear_obs();
        offer(8'h11);
        offer(8'h22);
        wait_ready_low("held");
        m_mosi[0] = 8'($urandom);
        m_mosi[1] = 8'($urandom);
        model_frame(2, 0);
        master_frame(2, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_miso[i] !== exp_miso[i]) begin
                errors++;
                $display("FAIL held_miso%0d: got %h expected %h", i, m_miso[i], exp_miso[i]);
            end
        end
        checks++;
        if (ur_cnt != exp_ur) begin
            errors++;
            $display("FAIL held_underrun: got %0d expected %0d", ur_cnt, exp_ur);
        end
    endtask

    task automatic test_partial_frame();
        clear_obs();
        m_mosi[0] = 8'($urandom);
        model_frame(0, 5);
        master_frame(0, 5);
        checks++;
        if (rx_log.size() != 0 || fe_cnt != 1) begin
            errors++;
            $display("FAIL partial_abort: rx count %0d fe %0d expected 0 and 1", rx_log.size(), fe_cnt);
        end
        checks++;
        if (ur_cnt != exp_ur) begin
            errors++;
            $display("FAIL partial_underrun: got %0d expected %0d", ur_cnt, exp_ur);
        end
        check_idle_outputs("partial_end");
        clear_obs();
        m_mosi[0] = 8'($urandom);
        model_frame(1, 0);
        master_frame(1, 0);
        checks++;
        if (rx_log.size() != 1 || rx_log[0] !== m_mosi[0]) begin
            errors++;
            $display("FAIL partial_next_rx: count %0d expected 1 word %h", rx_log.size(), m_mosi[0]);
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] w;
        clear_obs();
        w = 8'($urandom);
        spi_SS_n = 1'b0;
        for (int b = 0; b < 5; b++) begin
            spi_MOSI = w[7-b];
            repeat (4) @(negedge clk_clk);
            spi_SCLK = 1'b1;
            repeat (4) @(negedge clk_clk);
            if (b < 4) spi_SCLK = 1'b0;
        end
        reset_reset_n = 1'b0;
        spi_SS_n = 1'b1;
        spi_SCLK = 1'b0;
        repeat (3) @(negedge clk_clk);
        check_idle_outputs("midreset");
        checks++;
        if (rx_data !== 8'h00 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_regs: rx_data=%h tx_ready=%b expected 00 1", rx_data, tx_ready);
        end
        reset_reset_n = 1'b1;
        repeat (4) @(negedge clk_clk);
        clear_obs();
        m_mosi[0] = 8'($urandom);
        model_frame(1, 0);
        master_frame(1, 0);
        checks++;
        if (rx_log.size() != 1 || rx_log[0] !== m_mosi[0] || m_miso[0] !== exp_miso[0]) begin
            errors++;
            $display("FAIL midreset_next: rx count %0d miso %h expected 1 word %h miso %h",
                     rx_log.size(), m_miso[0], m_mosi[0], exp_miso[0]);
        end
    endtask

    task automatic test_idle_sclk();
        int bad;
        clear_obs();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            spi_MOSI = 1'($urandom);
            spi_SCLK = ~spi_SCLK;
            repeat (4) begin
                @(negedge clk_clk);
                if (spi_MISO_oe !== 1'b0 || spi_MISO !== 1'b1 || busy !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0 || rx_log.size() != 0 || ur_cnt != 0) begin
            errors++;
            $display("FAIL idle_sclk: bad cycles %0d rx %0d ur %0d expected 0 0 0", bad, rx_log.size(), ur_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int nwords;
        int ntx;
        for (int it = 0; it < 6; it++) begin
            clear_obs();
            nwords = $urandom_range(1, 3);
            ntx    = $urandom_range(0, 3);
            for (int k = 0; k < ntx; k++) offer(8'($urandom));
            for (int k = 0; k < nwords; k++) m_mosi[k] = 8'($urandom);
            repeat (6) @(negedge clk_clk);
            model_frame(nwords, 0);
            master_frame(nwords, 0);
            for (int k = 0; k < nwords; k++) begin
                checks++;
                if (m_miso[k] !== exp_miso[k]) begin
                    errors++;
                    $display("FAIL b2b_miso it%0d w%0d: got %h expected %h", it, k, m_miso[k], exp_miso[k]);
                end
                checks++;
                if (k >= rx_log.size() || rx_log[k] !== m_mosi[k]) begin
                    errors++;
                    $display("FAIL b2b_rx it%0d w%0d: count %0d expected %h", it, k, rx_log.size(), m_mosi[k]);
                end
            end
            checks++;
            if (rx_log.size() != nwords || ur_cnt != exp_ur || fe_cnt != 1) begin
                errors++;
                $display("FAIL b2b_counts it%0d: rx %0d ur %0d fe %0d expected %0d %0d 1",
                         it, rx_log.size(), ur_cnt, fe_cnt, nwords, exp_ur);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_preload();
        test_underrun();
        test_held_tx();
        test_partial_frame();
        test_reset_midword();
        test_idle_sclk();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
